// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop sync, per-phase debounce, x1/x2/x4 decode, wrapping position.
// Define QDEC_ERR_EN to build the sticky illegal-transition flag; otherwise err is tied low.
module quad_decoder #(
  parameter int DEB_CNT  = 80,
  parameter int DEB_BITS = 7,
  parameter int POS_W    = 8,
  parameter int MODE     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             cw,
  output logic             ccw,
  output logic             err
);

  // A debounced phase flips once it has differed for DEB_CNT+1 sampled cycles,
  // which puts the debounced edge at 2+DEB_CNT edges after the pin is first sampled.
  localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CNT);

  logic [1:0] raw;
  logic [1:0] deb;
  logic [1:0] prev_reg;

  assign raw = {a, b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_phase
      logic                sync1_reg;
      logic                sync2_reg;
      logic                deb_reg;
      logic [DEB_BITS-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign deb[gi] = deb_reg;
    end
  endgenerate

  // Map the Gray sequence 00,10,11,01 onto 0..3 so direction is a modulo-4 difference.
  logic [1:0] cur_idx;
  logic [1:0] prev_idx;
  logic [1:0] delta;
  logic       is_cw;
  logic       is_ccw;
  logic       illegal;
  logic       a_moved;
  logic       counted;

  assign cur_idx  = {deb[0], deb[1] ^ deb[0]};
  assign prev_idx = {prev_reg[0], prev_reg[1] ^ prev_reg[0]};
  assign delta    = cur_idx - prev_idx;
  assign is_cw    = (delta == 2'd1);
  assign is_ccw   = (delta == 2'd3);
  assign illegal  = (delta == 2'd2);
  assign a_moved  = prev_reg[1] ^ deb[1];

  always_comb begin
    counted = 1'b0;
    if (MODE == 0) begin
      counted = (is_cw && prev_reg == 2'b00) || (is_ccw && prev_reg == 2'b10);
    end else if (MODE == 1) begin
      counted = (is_cw || is_ccw) && a_moved;
    end else begin
      counted = is_cw || is_ccw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= 2'b00;
      pos      <= '0;
      step     <= 1'b0;
      dir      <= 1'b0;
      cw       <= 1'b0;
      ccw      <= 1'b0;
    end else begin
      prev_reg <= deb;
      step     <= counted;
      if (counted) begin
        dir <= is_cw;
        cw  <= is_cw;
        ccw <= is_ccw;
      end
      // clr overrides the position update but not the step/direction reporting.
      if (clr) begin
        pos <= '0;
      end else if (counted) begin
        pos <= is_cw ? pos + 1'b1 : pos - 1'b1;
      end
    end
  end

`ifdef QDEC_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: three instances (x4/8-bit, x1/8-bit, x4/4-bit) share the same encoder stimulus.
// A scoreboard queue holds the expected outputs and the edge at which each decoded transition must appear.
module tb_quad_decoder;
  localparam int DC   = 8;
  localparam int HOLD = 2 * DC;
  localparam int LAT  = 4 + DC;
`ifdef QDEC_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic clr = 1'b0;
  logic [7:0] pos0;
  logic [7:0] pos1;
  logic [3:0] pos2;
  logic [2:0] step_v, dir_v, cw_v, ccw_v, err_v;

  quad_decoder #(.DEB_CNT(DC), .DEB_BITS(4), .POS_W(8), .MODE(2)) u_x4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr), .pos(pos0), .step(step_v[0]),
    .dir(dir_v[0]), .cw(cw_v[0]), .ccw(ccw_v[0]), .err(err_v[0]));
  quad_decoder #(.DEB_CNT(DC), .DEB_BITS(4), .POS_W(8), .MODE(0)) u_x1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr), .pos(pos1), .step(step_v[1]),
    .dir(dir_v[1]), .cw(cw_v[1]), .ccw(ccw_v[1]), .err(err_v[1]));
  quad_decoder #(.DEB_CNT(DC), .DEB_BITS(4), .POS_W(4), .MODE(2)) u_w4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr), .pos(pos2), .step(step_v[2]),
    .dir(dir_v[2]), .cw(cw_v[2]), .ccw(ccw_v[2]), .err(err_v[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cls: 1 = CW, 2 = CCW, 3 = illegal; x1 marks the transitions an x1 decoder counts.
  typedef struct {
    logic [1:0] ab;
    logic [1:0] cls;
    logic       x1;
  } vec_t;

  typedef struct {
    int              due;
    logic [2:0]      step;
    logic [2:0][7:0] pos;
    logic [2:0]      dir;
    logic [2:0]      cw;
    logic [2:0]      ccw;
    logic [2:0]      err;
  } exp_t;

  vec_t vt[32];
  exp_t sbq[$];
  exp_t mon_e;

  logic [2:0][7:0] m_pos;
  logic [2:0]      m_dir, m_cw, m_ccw, m_err;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    m_pos = '0;
    m_dir = '0;
    m_cw  = '0;
    m_ccw = '0;
    m_err = '0;
  endtask

  task automatic model_clr();
    m_pos = '0;
    m_err = '0;
  endtask

  task automatic push(input logic [1:0] cls, input logic x1, input logic clr_now, input int t0);
    exp_t e;
    logic c;
    e.due = t0 + LAT;
    for (int k = 0; k < 3; k++) begin
      c = (cls == 2'd1 || cls == 2'd2) && (k != 1 || x1);
      e.step[k] = c;
      if (c) begin
        m_pos[k] = (cls == 2'd1) ? m_pos[k] + 8'd1 : m_pos[k] - 8'd1;
        m_dir[k] = (cls == 2'd1);
        m_cw[k]  = (cls == 2'd1);
        m_ccw[k] = (cls == 2'd2);
      end
      if (cls == 2'd3 && ERR_ON) m_err[k] = 1'b1;
      if (clr_now) begin
        m_pos[k] = '0;
        m_err[k] = 1'b0;
      end
    end
    e.pos = m_pos;
    e.dir = m_dir;
    e.cw  = m_cw;
    e.ccw = m_ccw;
    e.err = m_err;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [1:0] ab, input logic [1:0] cls, input logic x1, input int hold);
    @(posedge clk);
    #1;
    {a, b} = ab;
    push(cls, x1, 1'b0, cyc);
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
    end
    #1;
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_clr();
  endtask

  // Each transition is checked at exactly its due edge; every other cycle must be step-free.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      chk("sb_step", step_v, mon_e.step);
      chk("sb_pos_x4", pos0, mon_e.pos[0]);
      chk("sb_pos_x1", pos1, mon_e.pos[1]);
      chk("sb_pos_w4", pos2, mon_e.pos[2][3:0]);
      chk("sb_dir", dir_v, mon_e.dir);
      chk("sb_cw", cw_v, mon_e.cw);
      chk("sb_ccw", ccw_v, mon_e.ccw);
      chk("sb_err", err_v, mon_e.err);
    end else begin
      chk("idle_step", step_v, 3'b000);
    end
  end

  initial begin
    for (int c = 0; c < 4; c++) begin
      vt[4*c+0]      = '{ab: 2'b10, cls: 2'd1, x1: 1'b1};
      vt[4*c+1]      = '{ab: 2'b11, cls: 2'd1, x1: 1'b0};
      vt[4*c+2]      = '{ab: 2'b01, cls: 2'd1, x1: 1'b0};
      vt[4*c+3]      = '{ab: 2'b00, cls: 2'd1, x1: 1'b0};
      vt[16+4*c+0]   = '{ab: 2'b01, cls: 2'd2, x1: 1'b0};
      vt[16+4*c+1]   = '{ab: 2'b11, cls: 2'd2, x1: 1'b0};
      vt[16+4*c+2]   = '{ab: 2'b10, cls: 2'd2, x1: 1'b0};
      vt[16+4*c+3]   = '{ab: 2'b00, cls: 2'd2, x1: 1'b1};
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos_x4", pos0, 8'h00);
    chk("rst_pos_w4", pos2, 4'h0);
    chk("rst_flags", {step_v, dir_v, cw_v, ccw_v, err_v}, 15'h0);
    rst = 1'b0;

    // Four CW cycles
    for (int i = 0; i < 16; i++) drive(vt[i].ab, vt[i].cls, vt[i].x1, HOLD);
    drain();
    chk("cw4_pos_x4", pos0, 8'd16);
    chk("cw4_pos_x1", pos1, 8'd4);
    chk("cw4_pos_w4_wrap", pos2, 4'h0);
    chk("cw4_flags_x4", {dir_v[0], cw_v[0], ccw_v[0]}, 3'b110);

    // Four CCW cycles from zero
    clr_pulse();
    chk("clr_pos_x4", pos0, 8'h00);
    for (int i = 16; i < 32; i++) drive(vt[i].ab, vt[i].cls, vt[i].x1, HOLD);
    drain();
    chk("ccw4_pos_x1", pos1, 8'hFC);
    chk("ccw4_pos_x4", pos0, 8'hF0);
    chk("ccw4_flags_x1", {dir_v[1], cw_v[1], ccw_v[1]}, 3'b001);

    // Both phases together: illegal
    drive(2'b11, 2'd3, 1'b0, 2 * HOLD);
    drain();
    chk("illegal_err", err_v, {3{ERR_ON}});
    chk("illegal_pos_x4", pos0, 8'hF0);
    clr_pulse();
    chk("clr_err", err_v, 3'b000);
    chk("clr_pos_x1", pos1, 8'h00);
    drive(2'b00, 2'd3, 1'b0, HOLD);
    drain();
    clr_pulse();

    // Short glitch on a: filtered
    @(posedge clk);
    #1 a = 1'b1;
    repeat (DC - 1) @(posedge clk);
    #1 a = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
    chk("glitch_short_pos", pos0, 8'h00);

    // Long glitch on a: step on rise and on return
    drive(2'b10, 2'd1, 1'b1, DC + 2);
    drive(2'b00, 2'd2, 1'b1, HOLD);
    drain();
    chk("glitch_long_pos", pos0, 8'h00);

    // clr on the same edge as a CW step
    @(posedge clk);
    #1 {a, b} = 2'b10;
    push(2'd1, 1'b1, 1'b1, cyc);
    repeat (LAT - 1) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (HOLD) @(posedge clk);
    drive(2'b00, 2'd2, 1'b1, HOLD);
    drain();
    chk("ccw_to_ff_w4", pos2, 4'hF);
    drive(2'b10, 2'd1, 1'b1, HOLD);
    drain();
    chk("wrap_f_to_0_w4", pos2, 4'h0);
    drive(2'b00, 2'd2, 1'b1, HOLD);
    drain();

    // rst in the middle of a debounce count
    @(posedge clk);
    #1 a = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_pos", {pos0, pos1, pos2}, 20'h0);
    chk("midrst_flags", {step_v, dir_v, cw_v, ccw_v, err_v}, 15'h0);
    rst = 1'b0;
    model_reset();
    push(2'd1, 1'b1, 1'b0, cyc);
    repeat (HOLD) @(posedge clk);
    drain();
    chk("midrst_pos_after", pos0, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
